velocity_update_sequencer: RTL and testbench
============================================

# velocity_update_sequencer

Read-modify-write sequencer for one cell's velocity memory (the single-port `velocity_X_Y_Z` RAM, registered read output). Reads the particle count stored at address 0, then, for each particle, reads its velocity from the RAM and hands it to the motion-update unit over a valid/ready stream. It accepts the updated velocity back and writes it to the same address. One instance sits directly upstream of each cell's velocity RAM and owns that RAM's address, data and enable pins.

## Interface
Parameters:
- DATA_WIDTH, 96, velocity word {vz, vy, vx}, 3 × 32-bit float
- PARTICLE_NUM, 220, RAM depth; address 0 holds count, so max particles = PARTICLE_NUM-1
- ADDR_WIDTH, 8, RAM address width
- RAM_LATENCY, 1, cycles from ram_rden high to valid ram_q (≥1)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin one cell pass; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at pass end
- count_err  out  1  sticky: stored count exceeded PARTICLE_NUM-1; cleared by accepted start
- ram_address  out  ADDR_WIDTH  RAM address
- ram_data  out  DATA_WIDTH  RAM write data
- ram_rden  out  1  RAM read enable
- ram_wren  out  1  RAM write enable
- ram_q  in  DATA_WIDTH  RAM read data
- vel_out  out  DATA_WIDTH  current particle velocity to motion update
- vel_out_idx  out  ADDR_WIDTH  RAM address of vel_out (1..count)
- vel_out_valid  out  1
- vel_out_ready  in  1
- vel_in  in  DATA_WIDTH  updated velocity from motion update
- vel_in_valid  in  1
- vel_in_ready  out  1

## Operation
- States: IDLE, RD_CNT, WAIT_CNT, RD_VEL, WAIT_VEL, PRESENT, COLLECT, WRITE, DONE.
- IDLE: start=1 → RD_CNT; clear count_err.
- RD_CNT: ram_address=0, ram_rden=1, 1 cycle → WAIT_CNT.
- WAIT_CNT: RAM_LATENCY cycles. On the last cycle, capture count = ram_q[ADDR_WIDTH-1:0].
  - If count > PARTICLE_NUM-1: clamp to PARTICLE_NUM-1 and set count_err.
  - Set idx=1.
  - count=0 → DONE; otherwise → RD_VEL.
- RD_VEL: ram_address=idx, ram_rden=1, 1 cycle → WAIT_VEL.
- WAIT_VEL: RAM_LATENCY cycles. On the last cycle, register ram_q into vel_out → PRESENT.
- PRESENT: vel_out_valid=1, vel_out_idx=idx. Leave on the cycle vel_out_valid && vel_out_ready → COLLECT.
- COLLECT: vel_in_ready=1. On vel_in_valid, register vel_in into ram_data → WRITE.
- WRITE: ram_address=idx, ram_wren=1, ram_rden=0, 1 cycle.
  - idx==count → DONE.
  - Otherwise idx+1 → RD_VEL.
- DONE: done=1 for 1 cycle → IDLE.
- Enables: ram_rden is high only in RD_CNT/RD_VEL; ram_wren is high only in WRITE; they are never high together.
- The idx counter is ADDR_WIDTH bits and never wraps, because count ≤ PARTICLE_NUM-1 < 2^ADDR_WIDTH.
- No arithmetic on velocity data; words pass through bit-exact.

## Timing
- Reset values (async, immediate): state=IDLE, all outputs 0, including ram_address, ram_data, vel_out, vel_out_idx and count_err.
- Reset mid-pass aborts immediately. No write is issued after rst rises. A write in the same cycle as rst assertion is not guaranteed to complete.
- start while busy is ignored. start in DONE is ignored; it is accepted in the following IDLE cycle if still high.
- All outputs are registered (driven from state/registers, no input→output combinational path).
- Read-data capture: rden in cycle c → ram_q sampled at the end of cycle c+RAM_LATENCY.
- Output stream: vel_out/vel_out_idx are stable while vel_out_valid=1 and ready=0. vel_out_valid is never withdrawn without a handshake.
- Input stream: vel_in_valid outside COLLECT is ignored (ready=0). vel_in is not buffered.
- Pass length with start in cycle 0 and immediate handshakes (L=RAM_LATENCY, N=count): done is high in cycle 2+L+N·(L+4).
- Each PRESENT/COLLECT stall cycle adds exactly one cycle.

## Test plan
- Empty cell: addr0=0, L=1, start pulse → done in cycle 3. No ram_wren, no vel_out_valid, count_err=0.
- Three particles, addr0=3, always-ready, L=1. Motion update returns vel+{32'h1,32'h1,32'h1}.
  - done in cycle 18.
  - Writes occur to addrs 1,2,3 in order with the incremented words.
  - vel_out_idx sequence is 1,2,3.
- Backpressure: vel_out_ready low 5 cycles, and vel_in_valid delayed 3 cycles, on particle 2 of N=3.
  - vel_out holds stable through the stall.
  - done is delayed to cycle 26.
  - RAM contents are identical to the previous test.
- Overflow count: addr0=500 with PARTICLE_NUM=220.
  - count_err=1; exactly 219 writes (addrs 1..219).
  - count_err clears on the next start.
- L=2: N=2, always-ready → done in cycle 16; ram_q is captured two cycles after each rden.
- Reset mid-pass: assert rst during COLLECT of particle 2.
  - All outputs go to 0 the same cycle.
  - No later ram_wren; busy=0.
  - A new start runs a full correct pass.

Source files
------------

// File: rtl/velocity_update_sequencer.sv
// velocity_update_sequencer
// Read-modify-write sequencer for one cell's velocity RAM. It reads the
// particle count from address 0. For each particle it reads the stored
// velocity and streams it out to the motion-update unit. It then accepts the
// updated velocity back and writes it to the same RAM address.
// Velocity words pass through bit-exact.

module velocity_update_sequencer #(
   parameter int DATA_WIDTH   = 96,
   parameter int PARTICLE_NUM = 220,
   parameter int ADDR_WIDTH   = 8,
   parameter int RAM_LATENCY  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  count_err,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_rden,
   output logic                  ram_wren,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic [DATA_WIDTH-1:0] vel_out,
   output logic [ADDR_WIDTH-1:0] vel_out_idx,
   output logic                  vel_out_valid,
   input  logic                  vel_out_ready,
   input  logic [DATA_WIDTH-1:0] vel_in,
   input  logic                  vel_in_valid,
   output logic                  vel_in_ready
);

   localparam int LAT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
   localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(RAM_LATENCY - 1);
   localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_RD_CNT   = 4'd1;
   localparam logic [3:0] S_WAIT_CNT = 4'd2;
   localparam logic [3:0] S_RD_VEL   = 4'd3;
   localparam logic [3:0] S_WAIT_VEL = 4'd4;
   localparam logic [3:0] S_PRESENT  = 4'd5;
   localparam logic [3:0] S_COLLECT  = 4'd6;
   localparam logic [3:0] S_WRITE    = 4'd7;
   localparam logic [3:0] S_DONE     = 4'd8;

   logic [3:0]            state;
   logic [ADDR_WIDTH-1:0] idx;
   logic [ADDR_WIDTH-1:0] count;
   logic [LAT_W-1:0]      lat_cnt;
   logic [ADDR_WIDTH-1:0] stored_count;
   logic                  lat_done;

   assign stored_count = ram_q[ADDR_WIDTH-1:0];
   assign lat_done     = (lat_cnt == LAT_LAST);

   // Strobes and handshakes decoded purely from the registered state
   always_comb begin
      busy          = (state != S_IDLE);
      done          = (state == S_DONE);
      ram_rden      = (state == S_RD_CNT) || (state == S_RD_VEL);
      ram_wren      = (state == S_WRITE);
      vel_out_valid = (state == S_PRESENT);
      vel_in_ready  = (state == S_COLLECT);
   end

   // Pass sequencing, RAM address/data registers and captured words
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         idx         <= '0;
         count       <= '0;
         lat_cnt     <= '0;
         count_err   <= 1'b0;
         ram_address <= '0;
         ram_data    <= '0;
         vel_out     <= '0;
         vel_out_idx <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_RD_CNT;
                  count_err   <= 1'b0;
                  ram_address <= '0;
               end
            end
            S_RD_CNT: begin
               state   <= S_WAIT_CNT;
               lat_cnt <= '0;
            end
            S_WAIT_CNT: begin
               if (lat_done) begin
                  // Oversized counts are clamped so idx can never pass the RAM depth
                  if (stored_count > MAX_COUNT) begin
                     count     <= MAX_COUNT;
                     count_err <= 1'b1;
                  end else begin
                     count <= stored_count;
                  end
                  idx <= ADDR_WIDTH'(1);
                  if (stored_count == '0) begin
                     state <= S_DONE;
                  end else begin
                     state       <= S_RD_VEL;
                     ram_address <= ADDR_WIDTH'(1);
                  end
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            S_RD_VEL: begin
               state   <= S_WAIT_VEL;
               lat_cnt <= '0;
            end
            S_WAIT_VEL: begin
               if (lat_done) begin
                  vel_out     <= ram_q;
                  vel_out_idx <= idx;
                  state       <= S_PRESENT;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            S_PRESENT: begin
               if (vel_out_ready) begin
                  state <= S_COLLECT;
               end
            end
            S_COLLECT: begin
               if (vel_in_valid) begin
                  ram_data <= vel_in;
                  state    <= S_WRITE;
               end
            end
            S_WRITE: begin
               // ram_address already holds idx since RD_VEL
               if (idx == count) begin
                  state <= S_DONE;
               end else begin
                  idx         <= idx + 1'b1;
                  ram_address <= idx + 1'b1;
                  state       <= S_RD_VEL;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_velocity_update_sequencer.sv
// Testbench for velocity_update_sequencer: RAM models, a motion-update
// responder, and a pass-level reference model of the RAM contents and timing.
`timescale 1ns/1ps

module tb_velocity_update_sequencer;

   localparam int DW = 96;
   localparam int AW = 8;
   localparam int PN = 220;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   // Cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT with RAM_LATENCY=1 ----------------
   logic          start, busy, done, count_err, ram_rden, ram_wren;
   logic [AW-1:0] ram_address, vel_out_idx;
   logic [DW-1:0] ram_data, ram_q, vel_out, vel_in;
   logic          vel_out_valid, vel_out_ready, vel_in_valid, vel_in_ready;

   velocity_update_sequencer #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW), .RAM_LATENCY(1)) u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .count_err(count_err),
      .ram_address(ram_address), .ram_data(ram_data), .ram_rden(ram_rden), .ram_wren(ram_wren),
      .ram_q(ram_q), .vel_out(vel_out), .vel_out_idx(vel_out_idx), .vel_out_valid(vel_out_valid),
      .vel_out_ready(vel_out_ready), .vel_in(vel_in), .vel_in_valid(vel_in_valid),
      .vel_in_ready(vel_in_ready));

   // ---------------- DUT with RAM_LATENCY=2 ----------------
   logic          start2, busy2, done2, count_err2, ram_rden2, ram_wren2;
   logic [AW-1:0] ram_address2, vel_out_idx2;
   logic [DW-1:0] ram_data2, ram_q2, vel_out2, vel_in2;
   logic          vel_out_valid2, vel_out_ready2, vel_in_valid2, vel_in_ready2;

   velocity_update_sequencer #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW), .RAM_LATENCY(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .count_err(count_err2),
      .ram_address(ram_address2), .ram_data(ram_data2), .ram_rden(ram_rden2), .ram_wren(ram_wren2),
      .ram_q(ram_q2), .vel_out(vel_out2), .vel_out_idx(vel_out_idx2), .vel_out_valid(vel_out_valid2),
      .vel_out_ready(vel_out_ready2), .vel_in(vel_in2), .vel_in_valid(vel_in_valid2),
      .vel_in_ready(vel_in_ready2));

   // ---------------- RAM models and logs ----------------
   logic [DW-1:0] mem      [0:PN-1];
   logic [DW-1:0] init_mem [0:PN-1];
   logic [DW-1:0] exp_mem  [0:PN-1];
   logic [DW-1:0] mem2     [0:PN-1];
   logic [DW-1:0] init_mem2[0:PN-1];
   logic          ld = 1'b0, ld2 = 1'b0;
   logic [DW-1:0] q1, p0, q2;
   int            wr_addr[$], hs_idx[$], wr2_addr[$];
   logic [DW-1:0] wr_data[$], hs_data[$], wr2_data[$];
   int            both_en = 0;
   int            exp_n;

   // Single-port RAM, one-cycle registered read, plus transaction logs
   always @(posedge clk) begin
      if (ld) mem <= init_mem;
      else if (ram_wren) begin
         mem[ram_address] <= ram_data;
         wr_addr.push_back(int'(ram_address));
         wr_data.push_back(ram_data);
      end
      if (ram_rden) q1 <= mem[ram_address];
      if (vel_out_valid && vel_out_ready) begin
         hs_idx.push_back(int'(vel_out_idx));
         hs_data.push_back(vel_out);
      end
      if ((ram_rden && ram_wren) || (ram_rden2 && ram_wren2)) both_en <= both_en + 1;
   end
   assign ram_q = q1;

   // Single-port RAM with two-cycle read pipeline
   always @(posedge clk) begin
      if (ld2) mem2 <= init_mem2;
      else if (ram_wren2) begin
         mem2[ram_address2] <= ram_data2;
         wr2_addr.push_back(int'(ram_address2));
         wr2_data.push_back(ram_data2);
      end
      if (ram_rden2) p0 <= mem2[ram_address2];
      q2 <= p0;
   end
   assign ram_q2 = q2;

   function automatic logic [DW-1:0] lane_inc(input logic [DW-1:0] w);
      return {w[95:64] + 32'd1, w[63:32] + 32'd1, w[31:0] + 32'd1};
   endfunction

   // ---------------- motion-update responders ----------------
   int            stall_idx = 0, out_stall = 0, in_delay = 0, junk = 0;
   int            o_cnt = 0, i_cnt = 0;
   bit            unstable = 1'b0, held_v = 1'b0;
   logic [DW-1:0] held;

   initial begin
      vel_out_ready = 1'b0; vel_in_valid = 1'b0; vel_in = '0;
      forever begin
         @(posedge clk); #1;
         if (vel_out_valid) begin
            if (held_v && vel_out !== held) unstable = 1'b1;
            held = vel_out; held_v = 1'b1;
            if (int'(vel_out_idx) == stall_idx && o_cnt < out_stall) begin
               vel_out_ready = 1'b0; o_cnt++;
            end else vel_out_ready = 1'b1;
         end else begin
            held_v = 1'b0;
            vel_out_ready = 1'b0;
         end
         if (vel_in_ready) begin
            if (int'(vel_out_idx) == stall_idx && i_cnt < in_delay) begin
               vel_in_valid = 1'b0; vel_in = {$urandom, $urandom, $urandom}; i_cnt++;
            end else begin
               vel_in_valid = 1'b1; vel_in = lane_inc(vel_out);
            end
         end else if (junk != 0) begin
            vel_in_valid = 1'b1; vel_in = {$urandom, $urandom, $urandom};
         end else vel_in_valid = 1'b0;
      end
   end

   initial begin
      vel_out_ready2 = 1'b1; vel_in_valid2 = 1'b1; vel_in2 = '0;
      forever begin
         @(posedge clk); #1;
         vel_in2 = lane_inc(vel_out2);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic fill(input logic [DW-1:0] w0);
      init_mem[0] = w0;
      for (int a = 1; a < PN; a++) init_mem[a] = {$urandom, $urandom, $urandom};
   endtask

   task automatic load_ram();
      @(posedge clk); #1; ld = 1'b1;
      @(posedge clk); #1; ld = 1'b0;
   endtask

   // Reference: every particle 1..min(count,PN-1) gets each lane incremented
   task automatic model_pass();
      exp_n = (int'(init_mem[0][7:0]) > PN - 1) ? PN - 1 : int'(init_mem[0][7:0]);
      exp_mem = init_mem;
      for (int a = 1; a <= exp_n; a++) exp_mem[a] = lane_inc(init_mem[a]);
   endtask

   task automatic start_and_wait(output int lat);
      int t0;
      @(posedge clk); #1; start = 1'b1; t0 = cyc;
      @(posedge clk); #1; start = 1'b0;
      lat = -1;
      for (int k = 0; k < 5000; k++) begin
         if (done) begin lat = cyc - t0; break; end
         @(posedge clk); #1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1;
      n_checks++;
      if ({busy, done, count_err, ram_rden, ram_wren, vel_out_valid, vel_in_ready} !== 7'b0) begin
         n_fail++; $display("FAIL reset_flags got %b want 0", {busy, done, count_err, ram_rden, ram_wren, vel_out_valid, vel_in_ready});
      end
      n_checks++;
      if ({ram_address, vel_out_idx, ram_data, vel_out} !== '0) begin
         n_fail++; $display("FAIL reset_words got addr=%0d idx=%0d data=%h vel=%h want 0", ram_address, vel_out_idx, ram_data, vel_out);
      end
      @(posedge clk); #2; rst = 1'b0;
   endtask

   task automatic test_empty();
      logic [DW-1:0] w;
      int lat, wb, hb;
      w = {$urandom, $urandom, $urandom}; w[7:0] = 8'd0;
      fill(w); load_ram(); model_pass();
      wb = wr_addr.size(); hb = hs_idx.size();
      start_and_wait(lat);
      n_checks++;
      if (lat != 3) begin n_fail++; $display("FAIL empty_done_cycle got %0d want 3", lat); end
      n_checks++;
      if (count_err !== 1'b0) begin n_fail++; $display("FAIL empty_count_err got %b want 0", count_err); end
      @(posedge clk); #1;
      n_checks++;
      if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL empty_done_pulse got done,busy=%b want 00", {done, busy}); end
      n_checks++;
      if (wr_addr.size() != wb || hs_idx.size() != hb) begin
         n_fail++; $display("FAIL empty_no_traffic got writes=%0d handshakes=%0d want 0,0", wr_addr.size() - wb, hs_idx.size() - hb);
      end
   endtask

   task automatic check_pass(input string name, input int lat, input int exp_lat, input int wb, input int hb);
      // pass-level comparisons against the reference model
      n_checks++;
      if (lat != exp_lat) begin n_fail++; $display("FAIL %s_done_cycle got %0d want %0d", name, lat, exp_lat); end
      n_checks++;
      if (wr_addr.size() - wb != exp_n) begin n_fail++; $display("FAIL %s_write_count got %0d want %0d", name, wr_addr.size() - wb, exp_n); end
      for (int i = 0; i < exp_n && wb + i < wr_addr.size(); i++) begin
         n_checks++;
         if (wr_addr[wb+i] != i + 1 || wr_data[wb+i] !== exp_mem[i+1]) begin
            n_fail++; $display("FAIL %s_write[%0d] got addr=%0d data=%h want addr=%0d data=%h", name, i, wr_addr[wb+i], wr_data[wb+i], i + 1, exp_mem[i+1]);
         end
      end
      for (int i = 0; i < exp_n && hb + i < hs_idx.size(); i++) begin
         n_checks++;
         if (hs_idx[hb+i] != i + 1 || hs_data[hb+i] !== init_mem[i+1]) begin
            n_fail++; $display("FAIL %s_vel_out[%0d] got idx=%0d vel=%h want idx=%0d vel=%h", name, i, hs_idx[hb+i], hs_data[hb+i], i + 1, init_mem[i+1]);
         end
      end
      for (int a = 0; a < PN; a++) begin
         n_checks++;
         if (mem[a] !== exp_mem[a]) begin n_fail++; $display("FAIL %s_ram[%0d] got %h want %h", name, a, mem[a], exp_mem[a]); end
      end
   endtask

   logic [DW-1:0] three_init [0:PN-1];
   logic [DW-1:0] three_final[0:PN-1];

   task automatic test_three();
      logic [DW-1:0] w;
      int lat, wb, hb;
      w = {$urandom, $urandom, $urandom}; w[7:0] = 8'd3;
      fill(w); load_ram(); model_pass();
      three_init = init_mem;
      wb = wr_addr.size(); hb = hs_idx.size();
      start_and_wait(lat);
      check_pass("three", lat, 2 + 1 + exp_n * 5, wb, hb);
      n_checks++;
      if (hs_idx.size() - hb != 3) begin n_fail++; $display("FAIL three_handshakes got %0d want 3", hs_idx.size() - hb); end
      three_final = mem;
   endtask

   task automatic test_back_to_back_stall();
      int lat, wb, hb;
      init_mem = three_init; load_ram(); model_pass();
      stall_idx = 2; out_stall = 5; in_delay = 3; junk = 1; o_cnt = 0; i_cnt = 0; unstable = 1'b0;
      wb = wr_addr.size(); hb = hs_idx.size();
      start_and_wait(lat);
      check_pass("stall", lat, 26, wb, hb);
      n_checks++;
      if (unstable) begin n_fail++; $display("FAIL stall_vel_out_stable got changed want held"); end
      for (int a = 0; a < PN; a++) begin
         n_checks++;
         if (mem[a] !== three_final[a]) begin n_fail++; $display("FAIL stall_same_as_three[%0d] got %h want %h", a, mem[a], three_final[a]); end
      end
      stall_idx = 0; out_stall = 0; in_delay = 0; junk = 0;
   endtask

   task automatic test_overflow();
      int lat, wb, hb;
      fill(96'd500); load_ram(); model_pass();
      wb = wr_addr.size(); hb = hs_idx.size();
      start_and_wait(lat);
      check_pass("ovf", lat, 2 + 1 + (PN - 1) * 5, wb, hb);
      n_checks++;
      if (count_err !== 1'b1) begin n_fail++; $display("FAIL ovf_count_err got %b want 1", count_err); end
      fill(96'd2); load_ram(); model_pass();
      n_checks++;
      if (count_err !== 1'b1) begin n_fail++; $display("FAIL ovf_count_err_sticky got %b want 1", count_err); end
      wb = wr_addr.size(); hb = hs_idx.size();
      start_and_wait(lat);
      check_pass("ovf_next", lat, 2 + 1 + 2 * 5, wb, hb);
      n_checks++;
      if (count_err !== 1'b0) begin n_fail++; $display("FAIL ovf_count_err_cleared got %b want 0", count_err); end
   endtask

   task automatic test_latency2();
      logic [DW-1:0] w;
      int lat, t0, wb;
      w = {$urandom, $urandom, $urandom}; w[7:0] = 8'd2;
      fill(w); model_pass();
      init_mem2 = init_mem;
      @(posedge clk); #1; ld2 = 1'b1;
      @(posedge clk); #1; ld2 = 1'b0;
      wb = wr2_addr.size();
      @(posedge clk); #1; start2 = 1'b1; t0 = cyc;
      @(posedge clk); #1; start2 = 1'b0;
      lat = -1;
      for (int k = 0; k < 500; k++) begin
         if (done2) begin lat = cyc - t0; break; end
         @(posedge clk); #1;
      end
      n_checks++;
      if (lat != 2 + 2 + exp_n * 6) begin n_fail++; $display("FAIL lat2_done_cycle got %0d want %0d", lat, 2 + 2 + exp_n * 6); end
      n_checks++;
      if (wr2_addr.size() - wb != exp_n) begin n_fail++; $display("FAIL lat2_write_count got %0d want %0d", wr2_addr.size() - wb, exp_n); end
      for (int i = 0; i < exp_n && wb + i < wr2_addr.size(); i++) begin
         n_checks++;
         if (wr2_addr[wb+i] != i + 1 || wr2_data[wb+i] !== exp_mem[i+1]) begin
            n_fail++; $display("FAIL lat2_write[%0d] got addr=%0d data=%h want addr=%0d data=%h", i, wr2_addr[wb+i], wr2_data[wb+i], i + 1, exp_mem[i+1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] w;
      int lat, wb, hb, wc;
      bit seen;
      w = {$urandom, $urandom, $urandom}; w[7:0] = 8'd3;
      fill(w); load_ram(); model_pass();
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (vel_in_ready && vel_out_idx == 8'd2) begin seen = 1'b1; break; end
         @(posedge clk); #1;
      end
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL rstmid_reach_collect2 got timeout want COLLECT of particle 2"); end
      #1; rst = 1'b1; wc = wr_addr.size();
      #1;
      n_checks++;
      if ({busy, done, count_err, ram_rden, ram_wren, vel_out_valid, vel_in_ready} !== 7'b0) begin
         n_fail++; $display("FAIL rstmid_flags got %b want 0", {busy, done, count_err, ram_rden, ram_wren, vel_out_valid, vel_in_ready});
      end
      n_checks++;
      if ({ram_address, vel_out_idx, ram_data, vel_out} !== '0) begin
         n_fail++; $display("FAIL rstmid_words got addr=%0d idx=%0d data=%h vel=%h want 0", ram_address, vel_out_idx, ram_data, vel_out);
      end
      repeat (3) @(posedge clk);
      #2; rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (wr_addr.size() != wc || busy !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_no_write got writes=%0d busy=%b want 0,0", wr_addr.size() - wc, busy);
      end
      n_checks++;
      if (mem[2] !== init_mem[2] || mem[1] !== exp_mem[1]) begin
         n_fail++; $display("FAIL rstmid_ram_state got m1=%h m2=%h want m1=%h m2=%h", mem[1], mem[2], exp_mem[1], init_mem[2]);
      end
      init_mem = mem; model_pass();
      wb = wr_addr.size(); hb = hs_idx.size();
      start_and_wait(lat);
      check_pass("rstmid_rerun", lat, 18, wb, hb);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start2 = 1'b0;
      repeat (3) @(posedge clk);
      test_reset();
      test_empty();
      test_three();
      test_back_to_back_stall();
      test_overflow();
      test_latency2();
      test_reset_mid();
      n_checks++;
      if (both_en != 0) begin n_fail++; $display("FAIL rden_wren_exclusive got %0d overlaps want 0", both_en); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
